// File: rtl/dca_matrix_tile_walker_if.sv
// Tile walker bus: descriptor/control inputs and the tile descriptor stream.
interface dca_matrix_tile_walker_if #(
  parameter int TILE_NUM_ROW = 8,
  parameter int TILE_NUM_COL = 8,
  parameter int BW_ADDR      = 32,
  parameter int BW_STRIDE    = 16,
  parameter int BW_DIM       = 16
);
  localparam int W_TR = (TILE_NUM_ROW > 1) ? $clog2(TILE_NUM_ROW) : 1;
  localparam int W_TC = (TILE_NUM_COL > 1) ? $clog2(TILE_NUM_COL) : 1;

  // control and matrix descriptor
  logic                    clear;
  logic                    start;
  logic                    is_col_first;
  logic [BW_ADDR-1:0]      base_addr;
  logic [BW_STRIDE-1:0]    stride;
  logic [BW_DIM-1:0]       num_row_m1;
  logic [BW_DIM-1:0]       num_col_m1;
  logic [1:0]              elem_size_log2;
  logic                    busy;
  logic                    done;

  // tile descriptor stream
  logic                    tile_valid;
  logic                    tile_ready;
  logic [BW_ADDR-1:0]      tile_addr;
  logic [BW_DIM-1:0]       tile_row_idx;
  logic [BW_DIM-1:0]       tile_col_idx;
  logic [W_TR-1:0]         tile_num_row_m1;
  logic [W_TC-1:0]         tile_num_col_m1;
  logic [TILE_NUM_ROW-1:0] valid_row_list;
  logic [TILE_NUM_COL-1:0] valid_col_list;
  logic                    is_first_tile;
  logic                    is_last_tile;

  // walker side
  modport slave (
    input  clear, start, is_col_first, base_addr, stride, num_row_m1, num_col_m1,
           elem_size_log2, tile_ready,
    output busy, done, tile_valid, tile_addr, tile_row_idx, tile_col_idx,
           tile_num_row_m1, tile_num_col_m1, valid_row_list, valid_col_list,
           is_first_tile, is_last_tile
  );

  // control registers / LSU side
  modport master (
    output clear, start, is_col_first, base_addr, stride, num_row_m1, num_col_m1,
           elem_size_log2, tile_ready,
    input  busy, done, tile_valid, tile_addr, tile_row_idx, tile_col_idx,
           tile_num_row_m1, tile_num_col_m1, valid_row_list, valid_col_list,
           is_first_tile, is_last_tile
  );
endinterface

// File: rtl/dca_matrix_tile_walker.sv
// Walks a matrix in tiles of TILE_NUM_ROW x TILE_NUM_COL elements, emitting one
// tile descriptor per valid/ready handshake in row-first or column-first order.
module dca_matrix_tile_walker #(
  parameter int TILE_NUM_ROW = 8,
  parameter int TILE_NUM_COL = 8,
  parameter int BW_ADDR      = 32,
  parameter int BW_STRIDE    = 16,
  parameter int BW_DIM       = 16
) (
  input  logic clk,
  input  logic rst,
  dca_matrix_tile_walker_if.slave io_bus
);
  localparam int LOG_R = $clog2(TILE_NUM_ROW);
  localparam int LOG_C = $clog2(TILE_NUM_COL);
  localparam int W_TR  = (LOG_R > 0) ? LOG_R : 1;
  localparam int W_TC  = (LOG_C > 0) ? LOG_C : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state, w_state_next;
  logic [BW_DIM-1:0]   r_ty, r_tx, r_last_ty, r_last_tx;
  logic [BW_ADDR-1:0]  r_outer_base, r_cur_addr;
  logic [BW_STRIDE-1:0] r_stride;
  logic [1:0]          r_elem_log2;
  logic                r_col_first;
  logic [W_TR-1:0]     r_row_rem;
  logic [W_TC-1:0]     r_col_rem;
  logic                r_done;

  logic                w_run, w_hs, w_row_end, w_col_end, w_last, w_inner_end;
  logic [BW_ADDR-1:0]  w_row_step, w_col_step, w_outer_step, w_inner_step, w_outer_base_next;
  logic [W_TR-1:0]     w_row_rem_in, w_tile_rm1;
  logic [W_TC-1:0]     w_col_rem_in, w_tile_cm1;

  assign w_run     = (r_state == RUN);
  assign w_hs      = w_run && io_bus.tile_ready;
  assign w_row_end = (r_tx == r_last_tx);
  assign w_col_end = (r_ty == r_last_ty);
  assign w_last    = w_row_end && w_col_end;

  // Step sizes: one tile down is stride*TILE_NUM_ROW bytes, one tile right is
  // TILE_NUM_COL elements; both wrap modulo the address width.
  assign w_row_step   = BW_ADDR'(r_stride) << LOG_R;
  assign w_col_step   = BW_ADDR'(TILE_NUM_COL) << r_elem_log2;
  // The outer base tracks the start of the current tile row (row-first) or
  // tile column (column-first); a single register serves both orders.
  assign w_outer_step = r_col_first ? w_col_step : w_row_step;
  assign w_inner_step = r_col_first ? w_row_step : w_col_step;
  assign w_inner_end  = r_col_first ? w_col_end : w_row_end;
  assign w_outer_base_next = r_outer_base + w_outer_step;

  // Only the low index bits of the dimensions matter for clipping the last tile.
  generate
    if (LOG_R > 0) begin : g_row_rem
      assign w_row_rem_in = io_bus.num_row_m1[LOG_R-1:0];
    end else begin : g_row_rem_zero
      assign w_row_rem_in = '0;
    end
    if (LOG_C > 0) begin : g_col_rem
      assign w_col_rem_in = io_bus.num_col_m1[LOG_C-1:0];
    end else begin : g_col_rem_zero
      assign w_col_rem_in = '0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: clear beats the handshake, which beats start
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (!io_bus.clear && io_bus.start) w_state_next = RUN;
      RUN:  if (io_bus.clear || (w_hs && w_last)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Walk datapath: latch descriptor on start, advance indices/addresses on handshake
  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (rst || io_bus.clear || (w_hs && w_last)) begin
      r_ty <= '0;  r_tx <= '0;  r_last_ty <= '0;  r_last_tx <= '0;
      r_outer_base <= '0;  r_cur_addr <= '0;  r_stride <= '0;
      r_elem_log2 <= '0;  r_col_first <= 1'b0;  r_row_rem <= '0;  r_col_rem <= '0;
      r_done <= !rst && !io_bus.clear && w_hs && w_last;
    end else if (!w_run) begin
      if (io_bus.start) begin
        r_ty         <= '0;
        r_tx         <= '0;
        r_last_ty    <= io_bus.num_row_m1 >> LOG_R;
        r_last_tx    <= io_bus.num_col_m1 >> LOG_C;
        r_outer_base <= io_bus.base_addr;
        r_cur_addr   <= io_bus.base_addr;
        r_stride     <= io_bus.stride;
        r_elem_log2  <= io_bus.elem_size_log2;
        r_col_first  <= io_bus.is_col_first;
        r_row_rem    <= w_row_rem_in;
        r_col_rem    <= w_col_rem_in;
      end
    end else if (w_hs) begin
      if (w_inner_end) begin
        r_outer_base <= w_outer_base_next;
        r_cur_addr   <= w_outer_base_next;
        if (r_col_first) begin
          r_ty <= '0;
          r_tx <= r_tx + 1'b1;
        end else begin
          r_tx <= '0;
          r_ty <= r_ty + 1'b1;
        end
      end else begin
        r_cur_addr <= r_cur_addr + w_inner_step;
        if (r_col_first) r_ty <= r_ty + 1'b1;
        else             r_tx <= r_tx + 1'b1;
      end
    end
  end

  // Last tile in each direction is clipped to the remaining elements
  assign w_tile_rm1 = w_col_end ? r_row_rem : W_TR'(TILE_NUM_ROW - 1);
  assign w_tile_cm1 = w_row_end ? r_col_rem : W_TC'(TILE_NUM_COL - 1);

  assign io_bus.busy            = w_run;
  assign io_bus.tile_valid      = w_run;
  assign io_bus.done            = r_done;
  assign io_bus.tile_addr       = r_cur_addr;
  assign io_bus.tile_row_idx    = r_ty;
  assign io_bus.tile_col_idx    = r_tx;
  assign io_bus.tile_num_row_m1 = w_tile_rm1;
  assign io_bus.tile_num_col_m1 = w_tile_cm1;
  assign io_bus.is_first_tile   = w_run && (r_ty == '0) && (r_tx == '0);
  assign io_bus.is_last_tile    = w_run && w_last;

  genvar gi;
  generate
    for (gi = 0; gi < TILE_NUM_ROW; gi++) begin : g_row_mask
      assign io_bus.valid_row_list[gi] = w_run && (W_TR'(gi) <= w_tile_rm1);
    end
    for (gi = 0; gi < TILE_NUM_COL; gi++) begin : g_col_mask
      assign io_bus.valid_col_list[gi] = w_run && (W_TC'(gi) <= w_tile_cm1);
    end
  endgenerate
endmodule

// File: tb/tb_dca_matrix_tile_walker.sv
// Scoreboard bench for the tile walker: stimulus queues expected tiles, a
// monitor pops and compares on every handshake.
module tb_dca_matrix_tile_walker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dca_matrix_tile_walker_if #(.TILE_NUM_ROW(8), .TILE_NUM_COL(8), .BW_ADDR(32),
                              .BW_STRIDE(16), .BW_DIM(16)) bus ();

  dca_matrix_tile_walker #(.TILE_NUM_ROW(8), .TILE_NUM_COL(8), .BW_ADDR(32),
                           .BW_STRIDE(16), .BW_DIM(16)) dut (
    .clk(clk), .rst(rst), .io_bus(bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] ty;
    logic [15:0] tx;
    logic [2:0]  rm1;
    logic [2:0]  cm1;
    logic [7:0]  rl;
    logic [7:0]  cl;
    logic        first;
    logic        last;
  } tile_t;

  tile_t exp_q[$];
  tile_t tab[3][2];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic tile_t mk(input logic [31:0] a, input int ty, input int tx, input int rm1,
                               input int cm1, input logic [7:0] rl, input logic [7:0] cl,
                               input logic f, input logic l);
    tile_t t;
    t.addr = a; t.ty = 16'(ty); t.tx = 16'(tx); t.rm1 = 3'(rm1); t.cm1 = 3'(cm1);
    t.rl = rl; t.cl = cl; t.first = f; t.last = l;
    return t;
  endfunction

  function automatic tile_t cur_tile();
    tile_t t;
    t.addr = bus.tile_addr; t.ty = bus.tile_row_idx; t.tx = bus.tile_col_idx;
    t.rm1 = bus.tile_num_row_m1; t.cm1 = bus.tile_num_col_m1;
    t.rl = bus.valid_row_list; t.cl = bus.valid_col_list;
    t.first = bus.is_first_tile; t.last = bus.is_last_tile;
    return t;
  endfunction

  function automatic logic [127:0] all_outs();
    return {37'd0, bus.busy, bus.tile_valid, bus.done, cur_tile()};
  endfunction

  // Monitor: compare every handshake against the scoreboard, check stalls hold
  tile_t mon_prev, mon_exp;
  logic  mon_prev_stall = 1'b0;
  logic  mon_prev_abort = 1'b0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (mon_prev_stall && !mon_prev_abort)
      check("stall_hold", {bus.tile_valid, cur_tile()}, {1'b1, mon_prev});
    if (bus.tile_valid && bus.tile_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tile", cur_tile(), '0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tile", cur_tile(), mon_exp);
      end
    end
    mon_prev_stall = bus.tile_valid && !bus.tile_ready;
    mon_prev_abort = bus.clear || rst;
    mon_prev       = cur_tile();
  end

  task automatic push_order(input logic col_first);
    if (col_first) begin
      for (int x = 0; x < 2; x++) for (int y = 0; y < 3; y++) exp_q.push_back(tab[y][x]);
    end else begin
      for (int y = 0; y < 3; y++) for (int x = 0; x < 2; x++) exp_q.push_back(tab[y][x]);
    end
  endtask

  // Pulse start for one cycle; returns #1 into the first RUN cycle
  task automatic start_walk(input logic cf, input logic [31:0] base, input logic [15:0] strd,
                            input logic [15:0] nr, input logic [15:0] nc,
                            input logic [1:0] el, input logic rdy);
    bus.is_col_first = cf; bus.base_addr = base; bus.stride = strd;
    bus.num_row_m1 = nr; bus.num_col_m1 = nc; bus.elem_size_log2 = el;
    bus.tile_ready = rdy; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // With ready high: busy through n tiles, done pulse exactly in cycle T+n+1
  task automatic expect_done(input int n);
    for (int i = 0; i < n; i++) begin
      check("busy_run", {bus.busy, bus.done}, 2'b10);
      @(posedge clk); #1;
    end
    check("done_pulse", {bus.done, bus.busy, bus.tile_valid}, 3'b100);
    @(posedge clk); #1;
    check("done_one_cycle", {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, cyc;
    logic h;
    tab[0][0] = mk(32'h1000, 0, 0, 7, 7, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tab[0][1] = mk(32'h1020, 0, 1, 7, 1, 8'hFF, 8'h03, 1'b0, 1'b0);
    tab[1][0] = mk(32'h1200, 1, 0, 7, 7, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tab[1][1] = mk(32'h1220, 1, 1, 7, 1, 8'hFF, 8'h03, 1'b0, 1'b0);
    tab[2][0] = mk(32'h1400, 2, 0, 3, 7, 8'h0F, 8'hFF, 1'b0, 1'b0);
    tab[2][1] = mk(32'h1420, 2, 1, 3, 1, 8'h0F, 8'h03, 1'b0, 1'b1);

    rst = 1'b1; bus.clear = 1'b0; bus.start = 1'b0; bus.tile_ready = 1'b0;
    bus.is_col_first = 1'b0; bus.base_addr = '0; bus.stride = '0;
    bus.num_row_m1 = '0; bus.num_col_m1 = '0; bus.elem_size_log2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_outputs", all_outs(), '0);

    // Row-first 20x10, 4-byte elements
    push_order(1'b0);
    start_walk(1'b0, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b1);
    expect_done(6);
    bus.tile_ready = 1'b0;

    // Column-first, same descriptor
    push_order(1'b1);
    start_walk(1'b1, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b1);
    expect_done(6);
    bus.tile_ready = 1'b0;

    // Random backpressure, row-first
    push_order(1'b0);
    start_walk(1'b0, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b0);
    hs = 0; cyc = 0;
    while (hs < 6 && cyc < 300) begin
      bus.tile_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      h = bus.tile_valid && bus.tile_ready;
      @(posedge clk); #1;
      cyc++;
      if (h) hs++;
      check("bp_done", bus.done, h && hs == 6);
    end
    if (hs < 6) check("bp_timeout", 32'(hs), 32'd6);
    bus.tile_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_after_done", {bus.done, bus.busy}, 2'b00);

    // 1x1 matrix, ready high
    exp_q.push_back(mk(32'h2000, 0, 0, 0, 0, 8'h01, 8'h01, 1'b1, 1'b1));
    start_walk(1'b0, 32'h2000, 16'd64, 16'd0, 16'd0, 2'd2, 1'b1);
    expect_done(1);

    // 1x1 matrix, start during RUN ignored
    exp_q.push_back(mk(32'h2000, 0, 0, 0, 0, 8'h01, 8'h01, 1'b1, 1'b1));
    start_walk(1'b0, 32'h2000, 16'd64, 16'd0, 16'd0, 2'd2, 1'b0);
    bus.start = 1'b1; bus.base_addr = 32'h3000;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.tile_ready = 1'b1;
    check("start_in_run", {bus.busy, bus.done}, 2'b10);
    @(posedge clk); #1;
    check("done_1x1_late", bus.done, 1'b1);
    bus.tile_ready = 1'b0;
    @(posedge clk); #1;
    check("no_restart", {bus.busy, bus.done}, 2'b00);

    // Clear after the 2nd handshake, then restart from tile (0,0)
    exp_q.push_back(tab[0][0]);
    exp_q.push_back(tab[0][1]);
    start_walk(1'b0, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.tile_ready = 1'b0; bus.clear = 1'b1;
    @(posedge clk); #1;
    check("clear_abort", {bus.busy, bus.tile_valid, bus.done}, 3'b000);
    bus.clear = 1'b0;
    @(posedge clk); #1;
    check("clear_no_done", bus.done, 1'b0);
    push_order(1'b0);
    start_walk(1'b0, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b1);
    expect_done(6);
    bus.tile_ready = 1'b0;

    // Reset mid-run
    exp_q.push_back(tab[0][0]);
    start_walk(1'b0, 32'h1000, 16'd64, 16'd19, 16'd9, 2'd2, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; bus.tile_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_run", all_outs(), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Address wrap: 16x8, 1-byte elements
    exp_q.push_back(mk(32'hFFFF_FFF0, 0, 0, 7, 7, 8'hFF, 8'hFF, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h0000_07F0, 1, 0, 7, 7, 8'hFF, 8'hFF, 1'b0, 1'b1));
    start_walk(1'b0, 32'hFFFF_FFF0, 16'h0100, 16'd15, 16'd7, 2'd0, 1'b1);
    expect_done(2);
    bus.tile_ready = 1'b0;
    @(posedge clk); #1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
